// File: rtl/fp_pkg.sv
// Shared widths, constants, flag positions and FSM states for the
// single-precision normalise/round datapath.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int RAW_W  = 28;
  localparam int IEXP_W = 10;
  localparam int FLAG_W = 3;

  localparam logic [IEXP_W-1:0] EXP_BIAS = 10'd127;
  localparam logic [IEXP_W-1:0] EXP_MAX  = 10'd255;
  localparam logic [IEXP_W-1:0] EXP_ONE  = 10'd1;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and IEEE-754 single packing of a
// normalised (or denormal, exponent 1) raw mantissa.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic [IEXP_W-1:0] exp_in,
  input  logic [RAW_W-2:0]  mant,
  output logic [31:0]       result,
  output logic [FLAG_W-1:0] flags
);

  logic              guard_bit;
  logic              round_bit;
  logic              sticky_bit;
  logic              lsb_bit;
  logic              inc;
  logic [FRAC_W:0]   sig;
  logic [FRAC_W+1:0] sum;
  logic [IEXP_W-1:0] exp_fin;
  logic [FRAC_W-1:0] frac_fin;

  assign sig        = mant[RAW_W-2:3];
  assign guard_bit  = mant[2];
  assign round_bit  = mant[1];
  assign sticky_bit = mant[0];
  assign lsb_bit    = mant[3];
  assign inc        = guard_bit & (round_bit | sticky_bit | lsb_bit);
  assign sum        = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, inc};

  always_comb begin
    exp_fin  = exp_in;
    frac_fin = sum[FRAC_W-1:0];
    // A carry out renormalises to 1.0; a clear hidden bit marks a denormal.
    if (sum[FRAC_W+1]) begin
      exp_fin  = exp_in + EXP_ONE;
      frac_fin = '0;
    end else if (!sum[FRAC_W]) begin
      exp_fin = '0;
    end

    flags           = '0;
    flags[FLAG_INX] = guard_bit | round_bit | sticky_bit;
    if (exp_fin >= EXP_MAX) begin
      result          = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags[FLAG_OVF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else begin
      result          = {sign, exp_fin[EXP_W-1:0], frac_fin};
      flags[FLAG_UNF] = (exp_fin == '0);
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Multi-cycle normaliser: shifts the raw sum one bit per cycle until the
// hidden bit is set (or the exponent floor is hit), then rounds and packs.
module fp_normalize_round
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [RAW_W-1:0]  in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [FLAG_W-1:0] out_flags
);

  state_t              state_reg;
  logic                sign_reg;
  logic [IEXP_W-1:0]   exp_reg;
  logic [RAW_W-1:0]    mant_reg;
  logic [31:0]         rnd_result;
  logic [FLAG_W-1:0]   rnd_flags;

  assign in_ready = (state_reg == IDLE);

  fp_round_rne u_round (
    .sign   (sign_reg),
    .exp_in (exp_reg),
    .mant   (mant_reg[RAW_W-2:0]),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg <= in_sign;
            exp_reg  <= {{(IEXP_W-EXP_W){1'b0}}, in_exp};
            mant_reg <= in_mant;
            if (in_mant == '0) begin
              state_reg  <= DONE;
              out_valid  <= 1'b1;
              out_result <= {in_sign, 31'b0};
              out_flags  <= '0;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // Right shift keeps the dropped bit alive in sticky.
          if (mant_reg[RAW_W-1]) begin
            mant_reg <= {1'b0, mant_reg[RAW_W-1:2], mant_reg[1] | mant_reg[0]};
            exp_reg  <= exp_reg + EXP_ONE;
          end else if (!mant_reg[RAW_W-2] && (exp_reg > EXP_ONE)) begin
            mant_reg <= {mant_reg[RAW_W-2:0], 1'b0};
            exp_reg  <= exp_reg - EXP_ONE;
          end else begin
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          out_result <= rnd_result;
          out_flags  <= rnd_flags;
          out_valid  <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Table-driven scoreboard bench for fp_normalize_round, plus hand-written
// back-pressure and reset-abort sequences.
module tb_fp_normalize_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  e8;
    logic [27:0] mant;
    logic [31:0] result;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  flags;
    int          lat;
  } sb_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    sb_t e;
    int  cycles = 0;
    send(v.sign, v.e8, v.mant);
    sb_q.push_back('{v.result, v.flags, v.lat});
    while (!out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    e = sb_q.pop_front();
    check({name, " latency"}, cycles, e.lat);
    check({name, " result"}, out_result, e.result);
    check({name, " flags"}, {29'b0, out_flags}, {29'b0, e.flags});
    $display("%s: sign=%b exp=%0d mant=%h -> %h flags=%b after %0d edges",
             name, v.sign, v.e8, v.mant, out_result, out_flags, cycles);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    sb_t e;
    int  seen;

    vecs[0]  = '{1'b0, 8'd127, 28'hC000000, 32'h40400000, 3'b000, 3};
    vecs[1]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 3'b000, 25};
    vecs[2]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b001, 2};
    vecs[3]  = '{1'b0, 8'd254, 28'hC000000, 32'h7F800000, 3'b101, 3};
    vecs[4]  = '{1'b1, 8'd5,   28'h0000000, 32'h80000000, 3'b000, 0};
    vecs[5]  = '{1'b0, 8'd127, 28'h4000000, 32'h3F800000, 3'b000, 2};
    vecs[6]  = '{1'b1, 8'd127, 28'h6000000, 32'hBFC00000, 3'b000, 2};
    vecs[7]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001, 2};
    vecs[8]  = '{1'b0, 8'd127, 28'h4000006, 32'h3F800001, 3'b001, 2};
    vecs[9]  = '{1'b0, 8'd1,   28'h2000000, 32'h00400000, 3'b010, 2};
    vecs[10] = '{1'b0, 8'd3,   28'h0800000, 32'h00400000, 3'b010, 4};
    vecs[11] = '{1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 3'b001, 2};
    vecs[12] = '{1'b0, 8'd1,   28'h0000001, 32'h00000000, 3'b011, 2};
    vecs[13] = '{1'b1, 8'd254, 28'h7FFFFFC, 32'hFF800000, 3'b101, 2};
    vecs[14] = '{1'b0, 8'd254, 28'h7FFFFF8, 32'h7F7FFFFF, 3'b000, 2};
    vecs[15] = '{1'b0, 8'd127, 28'hC000001, 32'h40400000, 3'b001, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_flags", {29'b0, out_flags}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: zero result held for 5 cycles while new inputs are offered.
    send(1'b1, 8'd9, 28'h0);
    sb_q.push_back('{32'h80000000, 3'b000, 0});
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d valid", c), {31'b0, out_valid}, 32'd1);
      check($sformatf("hold%0d result", c), out_result, 32'h80000000);
      check($sformatf("hold%0d in_ready", c), {31'b0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'd127;
      in_mant  = 28'h4000000;
      tick();
    end
    in_valid = 1'b0;
    e = sb_q.pop_front();
    check("hold final result", out_result, e.result);
    check("hold final flags", {29'b0, out_flags}, {29'b0, e.flags});
    $display("hold: result %h held 5 cycles under back-pressure", out_result);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold release valid", {31'b0, out_valid}, 32'd0);
    check("hold release in_ready", {31'b0, in_ready}, 32'd1);

    // Reset two cycles into a long shift; the input offered under reset is ignored.
    send(1'b0, 8'd127, 28'h0000008);
    tick();
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mant  = 28'h4000000;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort no valid pulse", seen, 32'd0);
    check("abort idle in_ready", {31'b0, in_ready}, 32'd1);
    $display("abort: reset during SHIFT, %0d valid cycles seen afterwards", seen);
    run_vec(vecs[0], "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
